// File: rtl/seq_pattern_checker.sv
// seq_pattern_checker: locks onto period-5 cyclic code sequences A/B and reports position, period completion and mismatches.
module seq_pattern_checker #(
    parameter int LOSS_THRESH = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    output logic             locked,
    output logic             seq_id,
    output logic [2:0]       index,
    output logic             period_done,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    state_t           state_q, state_d;
    logic             locked_q, locked_d, seq_id_q, seq_id_d;
    logic [2:0]       index_q, index_d, exp_q, exp_d, miss_q, miss_d, exp_nxt;
    logic             period_done_q, period_done_d, err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    function automatic logic [2:0] next_code(input logic sid, input logic [2:0] c);
        case (c)
            3'b000:  return sid ? 3'b001 : 3'b100;
            3'b100:  return sid ? 3'b110 : 3'b010;
            3'b010:  return sid ? 3'b100 : 3'b001;
            3'b001:  return sid ? 3'b010 : 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    assign exp_nxt = next_code(seq_id_q, exp_q);

    always_comb begin
        state_d       = state_q;
        locked_d      = locked_q;
        seq_id_d      = seq_id_q;
        index_d       = index_q;
        exp_d         = exp_q;
        miss_d        = miss_q;
        period_done_d = 1'b0;
        err_d         = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: if (in_code == 3'b000) begin
                    state_d = SYNC;
                    index_d = 3'd0;
                end
                SYNC: if (in_code == 3'b100 || in_code == 3'b001) begin
                    state_d  = LOCK;
                    locked_d = 1'b1;
                    seq_id_d = in_code[0];
                    index_d  = 3'd1;
                    exp_d    = in_code;
                    miss_d   = 3'd0;
                end else if (in_code != 3'b000) begin
                    state_d = HUNT;
                    err_d   = 1'b1;
                end
                LOCK: begin
                    // flywheel advances even on a mismatch so a single corrupt sample keeps alignment
                    exp_d   = exp_nxt;
                    index_d = (index_q == 3'd4) ? 3'd0 : index_q + 3'd1;
                    if (in_code == exp_nxt) begin
                        miss_d        = 3'd0;
                        period_done_d = (index_q == 3'd4);
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + 3'd1;
                        if (miss_d == 3'(LOSS_THRESH)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            index_d  = 3'd0;
                            miss_d   = 3'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        err_count_d = (err_d && err_count_q != '1) ? err_count_q + ERR_W'(1) : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            locked_q      <= 1'b0;
            seq_id_q      <= 1'b0;
            index_q       <= 3'd0;
            exp_q         <= 3'd0;
            miss_q        <= 3'd0;
            period_done_q <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            locked_q      <= locked_d;
            seq_id_q      <= seq_id_d;
            index_q       <= index_d;
            exp_q         <= exp_d;
            miss_q        <= miss_d;
            period_done_q <= period_done_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign locked      = locked_q;
    assign seq_id      = seq_id_q;
    assign index       = index_q;
    assign period_done = period_done_q;
    assign err         = err_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_seq_pattern_checker.sv
// tb_seq_pattern_checker: directed scenarios plus randomized streams checked against a table-driven reference model.
module tb_seq_pattern_checker;
    logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic       locked, seq_id, period_done, err;
    logic [2:0] index;
    logic [7:0] err_count;
    logic       locked2, seq_id2, period_done2, err2;
    logic [2:0] index2;
    logic [1:0] err_count2;
    int n_tests = 0, n_fail = 0;

    seq_pattern_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
        .locked(locked), .seq_id(seq_id), .index(index), .period_done(period_done),
        .err(err), .err_count(err_count)
    );
    seq_pattern_checker #(.LOSS_THRESH(2), .ERR_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
        .locked(locked2), .seq_id(seq_id2), .index(index2), .period_done(period_done2),
        .err(err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    int seqs [2][5] = '{'{0, 4, 2, 1, 6}, '{0, 1, 2, 4, 6}};
    int m_state, m_sid, m_idx, m_miss, m_errs, m_pd, m_err;

    function automatic void model_step(input bit r, input bit v, input int c);
        int e;
        if (r) begin
            m_state = 0; m_sid = 0; m_idx = 0; m_miss = 0; m_errs = 0; m_pd = 0; m_err = 0;
            return;
        end
        m_pd = 0;
        m_err = 0;
        if (!v) return;
        if (m_state == 0) begin
            if (c == 0) begin m_state = 1; m_idx = 0; end
        end else if (m_state == 1) begin
            if (c == 4 || c == 1) begin
                m_state = 2; m_sid = (c == 1) ? 1 : 0; m_idx = 1; m_miss = 0;
            end else if (c != 0) begin
                m_state = 0; m_err = 1;
            end
        end else begin
            e = seqs[m_sid][(m_idx + 1) % 5];
            m_idx = (m_idx + 1) % 5;
            if (c == e) begin
                m_miss = 0; m_pd = (m_idx == 0) ? 1 : 0;
            end else begin
                m_err = 1; m_miss++;
                if (m_miss == 2) begin m_state = 0; m_idx = 0; m_miss = 0; end
            end
        end
        if (m_err == 1) m_errs++;
    endfunction

    task automatic cyc(input bit r, input bit v, input logic [2:0] c);
        @(negedge clk);
        reset = r; in_valid = v; in_code = c;
        @(posedge clk);
        #1;
        model_step(r, v, int'(c));
    endtask

    task automatic test_reset;
        cyc(1, 0, 3'd0);
        n_tests++;
        if ({locked, seq_id, index, period_done, err, err_count, err_count2} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: outputs=%h required 0", {locked, seq_id, index, period_done, err, err_count, err_count2});
        end
    endtask

    task automatic test_seq_a;
        logic [2:0] codes [6] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd6, 3'd0};
        logic [2:0] idx   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        cyc(1, 0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, codes[i]);
            n_tests++;
            if ({locked, index, period_done, err} !== {i > 0, idx[i], i == 5, 1'b0}) begin
                n_fail++;
                $display("FAIL seq_a[%0d]: lk/idx/pd/err=%b/%0d/%b/%b required %b/%0d/%b/0", i, locked, index, period_done, err, i > 0, idx[i], i == 5);
            end
        end
        n_tests++;
        if (seq_id !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL seq_a_end: seq_id=%b err_count=%0d required 0/0", seq_id, err_count);
        end
    endtask

    task automatic test_seq_b;
        logic [2:0] codes [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1};
        int pd_n = 0;
        cyc(1, 0, 3'd0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, codes[i]);
            pd_n += int'(period_done);
        end
        n_tests++;
        if (seq_id !== 1'b1 || locked !== 1'b1 || index !== 3'd1 || pd_n != 1 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL seq_b: seq_id=%b locked=%b index=%0d pd_count=%0d err_count=%0d required 1/1/1/1/0", seq_id, locked, index, pd_n, err_count);
        end
    endtask

    task automatic test_single_err;
        cyc(1, 0, 3'd0);
        cyc(0, 1, 3'd0); cyc(0, 1, 3'd4);
        cyc(0, 1, 3'd3);
        n_tests++;
        if (err !== 1'b1 || locked !== 1'b1 || index !== 3'd2 || period_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err_bad: err=%b locked=%b index=%0d pd=%b required 1/1/2/0", err, locked, index, period_done);
        end
        cyc(0, 1, 3'd1);
        n_tests++;
        if (err !== 1'b0 || locked !== 1'b1 || index !== 3'd3 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL single_err_good: err=%b locked=%b index=%0d err_count=%0d required 0/1/3/1", err, locked, index, err_count);
        end
    endtask

    task automatic test_loss;
        cyc(1, 0, 3'd0);
        cyc(0, 1, 3'd0); cyc(0, 1, 3'd4); cyc(0, 1, 3'd2);
        cyc(0, 1, 3'd6);
        n_tests++;
        if (locked !== 1'b1 || err !== 1'b1 || index !== 3'd3) begin
            n_fail++;
            $display("FAIL loss_first: locked=%b err=%b index=%0d required 1/1/3", locked, err, index);
        end
        cyc(0, 1, 3'd0);
        n_tests++;
        if (locked !== 1'b0 || err !== 1'b1 || index !== 3'd0 || err_count !== 8'd2 || period_done !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_second: locked=%b err=%b index=%0d err_count=%0d pd=%b required 0/1/0/2/0", locked, err, index, err_count, period_done);
        end
        cyc(0, 1, 3'd0); cyc(0, 1, 3'd1);
        n_tests++;
        if (locked !== 1'b1 || seq_id !== 1'b1 || index !== 3'd1) begin
            n_fail++;
            $display("FAIL relock_b: locked=%b seq_id=%b index=%0d required 1/1/1", locked, seq_id, index);
        end
    endtask

    task automatic test_sync_err;
        cyc(1, 0, 3'd0);
        cyc(0, 1, 3'd0); cyc(0, 1, 3'd2);
        n_tests++;
        if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL sync_err: err=%b locked=%b err_count=%0d required 1/0/1", err, locked, err_count);
        end
        cyc(0, 1, 3'd4);
        n_tests++;
        if (err !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_err_hunt: err=%b locked=%b required 0/0", err, locked);
        end
    endtask

    task automatic test_gaps;
        cyc(1, 0, 3'd0);
        cyc(0, 1, 3'd0); cyc(0, 1, 3'd4); cyc(0, 1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 3'($urandom_range(7)));
            n_tests++;
            if ({locked, index, period_done, err} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL gap[%0d]: lk/idx/pd/err=%b/%0d/%b/%b required 1/2/0/0", i, locked, index, period_done, err);
            end
        end
        cyc(0, 1, 3'd1);
        n_tests++;
        if (index !== 3'd3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_resume: index=%0d err=%b required 3/0", index, err);
        end
    endtask

    task automatic test_reset_mid;
        cyc(1, 0, 3'd0);
        cyc(0, 1, 3'd0); cyc(0, 1, 3'd4); cyc(0, 1, 3'd3); cyc(0, 1, 3'd1);
        cyc(1, 1, 3'd6);
        n_tests++;
        if ({locked, seq_id, index, period_done, err, err_count} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs=%h required 0", {locked, seq_id, index, period_done, err, err_count});
        end
    endtask

    task automatic test_saturation;
        cyc(1, 0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 3'd0); cyc(0, 1, 3'd2);
        end
        n_tests++;
        if (err_count2 !== 2'd3 || err_count !== 8'd5) begin
            n_fail++;
            $display("FAIL saturation: err_count(ERR_W=2)=%0d err_count(ERR_W=8)=%0d required 3/5", err_count2, err_count);
        end
    endtask

    task automatic test_random;
        int gsid = 0, gpos = 0;
        bit v;
        logic [2:0] c;
        cyc(1, 0, 3'd0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(39) == 0) begin gsid = 1 - gsid; gpos = 0; end
            v = $urandom_range(7) != 0;
            c = ($urandom_range(11) == 0) ? 3'($urandom_range(7)) : 3'(seqs[gsid][gpos]);
            if (v) gpos = (gpos + 1) % 5;
            cyc(0, v, c);
            n_tests++;
            if ({locked, index, period_done, err, err_count, err_count2} !==
                {m_state == 2, 3'(m_idx), m_pd == 1, m_err == 1, 8'(m_errs > 255 ? 255 : m_errs), 2'(m_errs > 3 ? 3 : m_errs)} ||
                (m_state == 2 && seq_id !== 1'(m_sid))) begin
                n_fail++;
                $display("FAIL random[%0d]: lk=%b sid=%b idx=%0d pd=%b err=%b cnt=%0d cnt2=%0d required lk=%0d sid=%0d idx=%0d pd=%0d err=%0d cnt=%0d",
                         i, locked, seq_id, index, period_done, err, err_count, err_count2, m_state == 2, m_sid, m_idx, m_pd, m_err, m_errs);
            end
        end
    endtask

    initial begin
        test_reset;
        test_seq_a;
        test_seq_b;
        test_single_err;
        test_loss;
        test_sync_err;
        test_gaps;
        test_reset_mid;
        test_saturation;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
